// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle MIPS-subset CPU: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and arbitrates the single memory port.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       mem_ack_i,
    input  logic       branch_take_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       mem_addr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] branch_type_o,
    output logic [2:0] state_o,
    output logic       instr_done_o,
    output logic [1:0] err_code_o
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BLT  = 6'd6;
    localparam logic [5:0] OP_BLE  = 6'd7;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_ORI  = 6'd13;
    localparam logic [5:0] OP_LI   = 6'd15;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERROR  = 3'd7
    } state_t;

    state_t        stateQ;
    logic [5:0]    opQ;
    logic [CW-1:0] waitCntQ;
    logic [1:0]    errQ;

    function automatic logic isBranch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BLE);
    endfunction

    function automatic logic goesToExec(input logic [5:0] op);
        return (op == OP_R) || (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LI) ||
               (op == OP_LW) || (op == OP_SW) || isBranch(op);
    endfunction

    // The wait counter only runs in the two memory-requesting states; an ack always wins
    // over the timeout, so the final allowed cycle can still succeed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ   <= FETCH;
            opQ      <= 6'd0;
            waitCntQ <= '0;
            errQ     <= 2'd0;
        end else begin
            case (stateQ)
                FETCH: begin
                    if (mem_ack_i) begin
                        stateQ   <= DECODE;
                        waitCntQ <= '0;
                    end else if (waitCntQ == WAIT_LAST) begin
                        stateQ <= ERROR;
                        errQ   <= 2'd2;
                    end else begin
                        waitCntQ <= waitCntQ + 1'b1;
                    end
                end
                DECODE: begin
                    opQ      <= instr_op_i;
                    waitCntQ <= '0;
                    if (goesToExec(instr_op_i)) begin
                        stateQ <= EXEC;
                    end else if (instr_op_i == OP_J) begin
                        stateQ <= FETCH;
                    end else if (instr_op_i == OP_JAL) begin
                        stateQ <= WB;
                    end else begin
                        stateQ <= ERROR;
                        errQ   <= 2'd1;
                    end
                end
                EXEC: begin
                    waitCntQ <= '0;
                    if ((opQ == OP_LW) || (opQ == OP_SW)) begin
                        stateQ <= MEM;
                    end else if (isBranch(opQ)) begin
                        stateQ <= FETCH;
                    end else begin
                        stateQ <= WB;
                    end
                end
                MEM: begin
                    if (mem_ack_i) begin
                        stateQ   <= (opQ == OP_SW) ? FETCH : WB;
                        waitCntQ <= '0;
                    end else if (waitCntQ == WAIT_LAST) begin
                        stateQ <= ERROR;
                        errQ   <= 2'd2;
                    end else begin
                        waitCntQ <= waitCntQ + 1'b1;
                    end
                end
                WB: begin
                    stateQ   <= FETCH;
                    waitCntQ <= '0;
                end
                ERROR: begin
                    stateQ <= ERROR;
                end
                default: begin
                    stateQ <= ERROR;
                end
            endcase
        end
    end

    // Control decode; DECODE looks at the live opcode because opQ only loads at its end.
    always_comb begin
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_src_o = 1'b0;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        pc_src_o       = 2'd0;
        reg_write_o    = 1'b0;
        reg_dst_o      = 2'd0;
        mem_to_reg_o   = 2'd0;
        alu_src_o      = 1'b0;
        alu_op_o       = 3'b000;
        branch_type_o  = 2'd0;
        instr_done_o   = 1'b0;
        state_o        = rst_i ? 3'd0 : stateQ;
        err_code_o     = rst_i ? 2'd0 : errQ;
        if (!rst_i) begin
            case (stateQ)
                FETCH: begin
                    mem_req_o  = 1'b1;
                    ir_write_o = mem_ack_i;
                    pc_write_o = mem_ack_i;
                end
                DECODE: begin
                    if (instr_op_i == OP_J) begin
                        pc_write_o   = 1'b1;
                        pc_src_o     = 2'd2;
                        instr_done_o = 1'b1;
                    end
                end
                EXEC: begin
                    case (opQ)
                        OP_R: alu_op_o = 3'b100;
                        OP_ADDI, OP_LW, OP_SW: begin
                            alu_src_o = 1'b1;
                            alu_op_o  = 3'b000;
                        end
                        OP_ORI: begin
                            alu_src_o = 1'b1;
                            alu_op_o  = 3'b101;
                        end
                        OP_LI: begin
                            alu_src_o = 1'b1;
                            alu_op_o  = 3'b111;
                        end
                        OP_BEQ, OP_BNE, OP_BLT, OP_BLE: begin
                            alu_op_o     = 3'b010;
                            pc_src_o     = 2'd1;
                            pc_write_o   = branch_take_i;
                            instr_done_o = 1'b1;
                            case (opQ)
                                OP_BLE:  branch_type_o = 2'd1;
                                OP_BLT:  branch_type_o = 2'd2;
                                OP_BNE:  branch_type_o = 2'd3;
                                default: branch_type_o = 2'd0;
                            endcase
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    mem_req_o      = 1'b1;
                    mem_addr_src_o = 1'b1;
                    mem_we_o       = (opQ == OP_SW);
                    instr_done_o   = mem_ack_i && (opQ == OP_SW);
                end
                WB: begin
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                    case (opQ)
                        OP_R:   reg_dst_o = 2'd1;
                        OP_LI:  mem_to_reg_o = 2'd2;
                        OP_LW:  mem_to_reg_o = 2'd1;
                        OP_JAL: begin
                            reg_dst_o    = 2'd2;
                            mem_to_reg_o = 2'd3;
                            pc_write_o   = 1'b1;
                            pc_src_o     = 2'd2;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
